load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: decodes one memory op, runs a single-beat bus transfer
// with timeout, and returns an aligned/extended load result or an error cause.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_valid_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic [1:0]  lsu_err_cause_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << lo;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // funct3[2] clear means signed (LB/LH); LW ignores it
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic        sgn;
        logic [31:0] r;
        sh  = rd >> {lo, 3'b000};
        sgn = ~f3[2];
        case (f3[1:0])
            2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lo_q, lo_d;
    logic             flushed_q, flushed_d;
    logic             req_q, req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;

    // State register and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            flushed_q <= 1'b0;
            req_q     <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= 32'h0000_0000;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            flushed_q <= flushed_d;
            req_q     <= req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state, decode and bus/response control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        flushed_d = flushed_q;
        req_d     = req_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cause_d   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (lsu_valid_i && !flush_i) begin
                    we_d      = lsu_we_i;
                    f3_d      = lsu_funct3_i;
                    lo_d      = lsu_addr_i[1:0];
                    flushed_d = 1'b0;
                    if (!f3_legal(lsu_we_i, lsu_funct3_i)) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned(lsu_funct3_i[1:0], lsu_addr_i[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d  = ST_BUS;
                        cnt_d    = {CNT_W{1'b0}};
                        req_d    = 1'b1;
                        mem_we_d = lsu_we_i;
                        addr_d   = {lsu_addr_i[31:2], 2'b00};
                        be_d     = byte_en(lsu_funct3_i[1:0], lsu_addr_i[1:0]);
                        wdata_d  = lane_data(lsu_funct3_i[1:0], lsu_wdata_i);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // A flush here only silences the response; the bus beat still finishes
                flushed_d = flushed_q | flush_i;
                if (mem_ready_i || (cnt_q == CNT_LAST)) begin
                    state_d  = ST_RESP;
                    req_d    = 1'b0;
                    mem_we_d = 1'b0;
                    addr_d   = 32'h0000_0000;
                    be_d     = 4'b0000;
                    wdata_d  = 32'h0000_0000;
                    if (flushed_d) begin
                        done_d = 1'b0;
                    end else if (mem_ready_i) begin
                        done_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = load_ext(f3_q, lo_q, mem_rdata_i);
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        err_d   = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall request and flush-qualified response pulses
    always_comb begin
        lsu_busy_o = 1'b0;
        case (state_q)
            ST_IDLE: lsu_busy_o = rst_ni & lsu_valid_i & ~flush_i;
            ST_BUS:  lsu_busy_o = 1'b1;
            default: lsu_busy_o = 1'b0;
        endcase
        lsu_done_o = done_q & ~flush_i;
        lsu_err_o  = err_q & ~flush_i;
        if (lsu_err_o) begin
            lsu_err_cause_o = cause_q;
        end else begin
            lsu_err_cause_o = 2'b00;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign lsu_rdata_o = rdata_q;

endmodule
